// File: rtl/hazard_forward_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl_if
//
// Bundles the ID-stage hazard inputs and the pipeline control outputs of
// hazard_forward_ctrl.
//   master : pipeline side. Drives the ID instruction fields, ex_done,
//            branch_taken and ext_stall. Receives pc_write, if_id_write,
//            if_id_flush, id_ex_bubble, ex_start and rs1/rs2_forward.
//   slave  : the hazard controller (the reverse directions).
// -----------------------------------------------------------------------------
interface hazard_forward_ctrl_if #(
   parameter int REG_ADDR_W = 5
);
   // ID-stage instruction
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic                  id_multicycle;

   // Pipeline events
   logic                  ex_done;
   logic                  branch_taken;
   logic                  ext_stall;

   // Controls back to the pipeline
   logic                  pc_write;
   logic                  if_id_write;
   logic                  if_id_flush;
   logic                  id_ex_bubble;
   logic                  ex_start;
   logic [1:0]            rs1_forward;
   logic [1:0]            rs2_forward;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_mem_read, id_multicycle,
             ex_done, branch_taken, ext_stall,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_start,
             rs1_forward, rs2_forward
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_mem_read, id_multicycle,
             ex_done, branch_taken, ext_stall,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_start,
             rs1_forward, rs2_forward
   );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
//
// Pipeline sequencing controller for the EX-stage operand muxes. Shadows the
// destination info of the instructions in EX and MEM, produces registered
// rs1/rs2 forward selects (00 regfile, 01 EX/MEM, 10 MEM/WB) and the
// stall / flush / bubble controls for load-use hazards, taken branches,
// external memory wait and multi-cycle EX operations.
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-high reset
//   bus (slave)    ID instruction fields, ex_done, branch_taken, ext_stall in;
//                  pc_write, if_id_write, if_id_flush, id_ex_bubble,
//                  ex_start, rs1_forward, rs2_forward out
//   perf_load_use, perf_flush, perf_ex_wait
//                  saturating event counters (only with HAZARD_PERF_EN)
//
// Build option: define HAZARD_PERF_EN to add the performance counters and
// the PERF_W parameter.
// -----------------------------------------------------------------------------
module hazard_forward_ctrl #(
   parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_EN
   ,
   parameter int PERF_W     = 32
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   hazard_forward_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0]    perf_load_use,
   output logic [PERF_W-1:0]    perf_flush,
   output logic [PERF_W-1:0]    perf_ex_wait
`endif
);

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_EX_WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
      logic                  valid;
   } shadow_t;

   // Shadow slots: index 0 tracks the instruction in EX, index 1 the one in MEM.
   localparam int EX  = 0;
   localparam int MEM = 1;

   state_e     state_q, state_d;
   shadow_t    sh_q [2];
   shadow_t    sh_d [2];
   logic [1:0] rs1_fwd_q, rs1_fwd_d;
   logic [1:0] rs2_fwd_q, rs2_fwd_d;
   logic       ex_start_q, ex_start_d;

   function automatic logic reg_hit(input shadow_t                s,
                                    input logic [REG_ADDR_W-1:0] rs,
                                    input logic                  use_rs);
      // x0 is hardwired, so a producer targeting it never forwards.
      return s.valid && s.reg_write && (s.rd != '0) && (s.rd == rs) && use_rs;
   endfunction

   // The youngest producer (EX) wins over the older one (MEM).
   function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
      if (hit_ex)  return 2'b01;
      if (hit_mem) return 2'b10;
      return 2'b00;
   endfunction

   // ---------------------------------------------------------------- hazards
   logic hit_ex_rs1, hit_ex_rs2, hit_mem_rs1, hit_mem_rs2;
   logic load_use_hzd;

   assign hit_ex_rs1  = reg_hit(sh_q[EX],  bus.id_rs1, bus.id_use_rs1);
   assign hit_ex_rs2  = reg_hit(sh_q[EX],  bus.id_rs2, bus.id_use_rs2);
   assign hit_mem_rs1 = reg_hit(sh_q[MEM], bus.id_rs1, bus.id_use_rs1);
   assign hit_mem_rs2 = reg_hit(sh_q[MEM], bus.id_rs2, bus.id_use_rs2);

   // A load in EX has no data yet; its consumer waits one cycle and then
   // picks the value up from MEM/WB.
   assign load_use_hzd = bus.id_valid & sh_q[EX].mem_read & (hit_ex_rs1 | hit_ex_rs2);

   // ------------------------------------------------------ pipeline controls
   logic pc_write_c, if_id_write_c, flush_c, bubble_c, load_use_c;

   always_comb begin
      // NOTE: every signal gets its default before the priority chain so no
      // path leaves it unassigned, which would infer a latch.
      pc_write_c    = 1'b1;
      if_id_write_c = 1'b1;
      flush_c       = 1'b0;
      bubble_c      = 1'b0;
      load_use_c    = 1'b0;
      if (rst) begin
         // Defaults already match the reset state of the pipe.
      end else if (bus.ext_stall || state_q == ST_EX_WAIT) begin
         pc_write_c    = 1'b0;
         if_id_write_c = 1'b0;
      end else if (bus.branch_taken) begin
         // The flush already removes the ID instruction, so a load-use
         // stall on it would be pointless.
         flush_c  = 1'b1;
         bubble_c = 1'b1;
      end else if (load_use_hzd) begin
         load_use_c    = 1'b1;
         pc_write_c    = 1'b0;
         if_id_write_c = 1'b0;
         bubble_c      = 1'b1;
      end
   end

   logic advance, id_enters;

   // The pipe moves only while running and memory is ready.
   assign advance   = (state_q == ST_RUN) & ~bus.ext_stall;
   assign id_enters = advance & bus.id_valid & ~bubble_c;

   // ---------------------------------------------------------- next state
   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      rs1_fwd_d  = rs1_fwd_q;
      rs2_fwd_d  = rs2_fwd_q;
      ex_start_d = 1'b0;

      if (advance) begin
         sh_d[MEM] = sh_q[EX];
         sh_d[EX]  = '0;
         rs1_fwd_d = 2'b00;
         rs2_fwd_d = 2'b00;
         if (id_enters) begin
            sh_d[EX].rd        = bus.id_rd;
            sh_d[EX].reg_write = bus.id_reg_write;
            sh_d[EX].mem_read  = bus.id_mem_read;
            sh_d[EX].valid     = 1'b1;
            rs1_fwd_d          = fwd_sel(hit_ex_rs1, hit_mem_rs1);
            rs2_fwd_d          = fwd_sel(hit_ex_rs2, hit_mem_rs2);
            if (bus.id_multicycle) begin
               state_d    = ST_EX_WAIT;
               ex_start_d = 1'b1;
            end
         end
      end else if (state_q == ST_EX_WAIT && bus.ex_done) begin
         // The ex_done cycle itself still holds; the pipe resumes next cycle.
         // ext_stall does not gate this exit.
         state_d = ST_RUN;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         sh_q[EX]   <= '0;
         sh_q[MEM]  <= '0;
         rs1_fwd_q  <= 2'b00;
         rs2_fwd_q  <= 2'b00;
         ex_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         rs1_fwd_q  <= rs1_fwd_d;
         rs2_fwd_q  <= rs2_fwd_d;
         ex_start_q <= ex_start_d;
      end
   end

   assign bus.pc_write     = pc_write_c;
   assign bus.if_id_write  = if_id_write_c;
   assign bus.if_id_flush  = flush_c;
   assign bus.id_ex_bubble = bubble_c;
   assign bus.ex_start     = ex_start_q;
   assign bus.rs1_forward  = rs1_fwd_q;
   assign bus.rs2_forward  = rs2_fwd_q;

`ifdef HAZARD_PERF_EN
   // ----------------------------------------------------- perf counters
   logic [PERF_W-1:0] load_use_cnt_q, load_use_cnt_d;
   logic [PERF_W-1:0] flush_cnt_q,    flush_cnt_d;
   logic [PERF_W-1:0] ex_wait_cnt_q,  ex_wait_cnt_d;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v,
                                                 input logic              en);
      return (en && v != '1) ? v + PERF_W'(1) : v;
   endfunction

   always_comb begin
      load_use_cnt_d = sat_inc(load_use_cnt_q, load_use_c);
      flush_cnt_d    = sat_inc(flush_cnt_q,    flush_c);
      ex_wait_cnt_d  = sat_inc(ex_wait_cnt_q,  state_q == ST_EX_WAIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_use_cnt_q <= '0;
         flush_cnt_q    <= '0;
         ex_wait_cnt_q  <= '0;
      end else begin
         load_use_cnt_q <= load_use_cnt_d;
         flush_cnt_q    <= flush_cnt_d;
         ex_wait_cnt_q  <= ex_wait_cnt_d;
      end
   end

   assign perf_load_use = load_use_cnt_q;
   assign perf_flush    = flush_cnt_q;
   assign perf_ex_wait  = ex_wait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_ctrl
//
// Directed scenarios for forwarding, load-use, branch flush, multi-cycle EX,
// external stall and reset, followed by randomized stimulus compared against
// an in-flight-instruction reference model. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_forward_ctrl;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hazard_forward_ctrl_if #(.REG_ADDR_W(AW)) bus ();

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_load_use, perf_flush, perf_ex_wait;
`endif

   hazard_forward_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus)
`ifdef HAZARD_PERF_EN
      ,
      .perf_load_use (perf_load_use),
      .perf_flush    (perf_flush),
      .perf_ex_wait  (perf_ex_wait)
`endif
   );

   int n_run  = 0;
   int n_fail = 0;

   // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
   logic [3:0] ctrl;
   assign ctrl = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble};

   // ------------------------------------------------------ reference model
   // The model keeps the instructions in flight (EX first, MEM second) and
   // derives the forward code from how far back the youngest producer sits.
   typedef struct packed {
      logic [AW-1:0] rd;
      logic          wr;
      logic          ld;
   } slot_t;
   localparam slot_t NOP = '0;

   slot_t       m_pipe [2];
   bit          m_wait, m_start;
   logic [1:0]  m_f1, m_f2;
   int unsigned m_lu, m_fl, m_ew;

   function automatic int producer_dist(input logic [AW-1:0] src, input logic use_it);
      if (!use_it || src == '0) return 0;
      for (int i = 0; i < 2; i++)
         if (m_pipe[i].wr && m_pipe[i].rd == src) return i + 1;
      return 0;
   endfunction

   function automatic bit m_load_use();
      return bus.id_valid && m_pipe[0].ld &&
             (producer_dist(bus.id_rs1, bus.id_use_rs1) == 1 ||
              producer_dist(bus.id_rs2, bus.id_use_rs2) == 1);
   endfunction

   function automatic logic [3:0] m_ctrl();
      if (bus.ext_stall || m_wait) return 4'b0000;
      if (bus.branch_taken)        return 4'b1111;
      if (m_load_use())            return 4'b0001;
      return 4'b1100;
   endfunction

   always @(posedge clk or posedge rst) begin : model_step
      slot_t incoming;
      bit    enters;
      if (rst) begin
         m_pipe[0] <= NOP;
         m_pipe[1] <= NOP;
         m_wait    <= 1'b0;
         m_start   <= 1'b0;
         m_f1      <= 2'b00;
         m_f2      <= 2'b00;
         m_lu      <= 0;
         m_fl      <= 0;
         m_ew      <= 0;
      end else begin
         if (m_ctrl() == 4'b0001) m_lu <= m_lu + 1;
         if (m_ctrl() == 4'b1111) m_fl <= m_fl + 1;
         if (m_wait)              m_ew <= m_ew + 1;
         m_start <= 1'b0;
         if (m_wait) begin
            if (bus.ex_done) m_wait <= 1'b0;
         end else if (!bus.ext_stall) begin
            enters   = bus.id_valid && !bus.branch_taken && !m_load_use();
            incoming = NOP;
            if (enters) begin
               incoming.rd = bus.id_rd;
               incoming.wr = bus.id_reg_write;
               incoming.ld = bus.id_mem_read;
            end
            m_pipe[1] <= m_pipe[0];
            m_pipe[0] <= incoming;
            m_f1 <= enters ? 2'(producer_dist(bus.id_rs1, bus.id_use_rs1)) : 2'b00;
            m_f2 <= enters ? 2'(producer_dist(bus.id_rs2, bus.id_use_rs2)) : 2'b00;
            if (enters && bus.id_multicycle) begin
               m_wait  <= 1'b1;
               m_start <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.id_valid      = 1'b0;
      bus.id_rs1        = '0;
      bus.id_rs2        = '0;
      bus.id_use_rs1    = 1'b0;
      bus.id_use_rs2    = 1'b0;
      bus.id_rd         = '0;
      bus.id_reg_write  = 1'b0;
      bus.id_mem_read   = 1'b0;
      bus.id_multicycle = 1'b0;
      bus.ex_done       = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.ext_stall     = 1'b0;
   endtask

   task automatic set_id(input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic u1,
                         input logic [AW-1:0] rs2, input logic u2,
                         input logic wr, input logic ld, input logic mc);
      bus.id_valid      = 1'b1;
      bus.id_rd         = rd;
      bus.id_rs1        = rs1;
      bus.id_use_rs1    = u1;
      bus.id_rs2        = rs2;
      bus.id_use_rs2    = u2;
      bus.id_reg_write  = wr;
      bus.id_mem_read   = ld;
      bus.id_multicycle = mc;
   endtask

   // ------------------------------------------------------------ scenarios
   task automatic test_reset();
      set_idle();
      #1 rst = 1'b1;
      @(negedge clk);
      n_run++; if (ctrl !== 4'b1100) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=1100", ctrl); end
      n_run++; if ({bus.ex_start, bus.rs1_forward, bus.rs2_forward} !== 5'b0)
         begin n_fail++; $display("FAIL reset_regs got=%b exp=00000", {bus.ex_start, bus.rs1_forward, bus.rs2_forward}); end
      bus.ext_stall = 1'b1;
      #1;
      n_run++; if (ctrl !== 4'b1100) begin n_fail++; $display("FAIL reset_over_stall got=%b exp=1100", ctrl); end
      bus.ext_stall = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      set_idle(); tick();
      set_id(5, 0, 0, 0, 0, 1, 0, 0); tick();                    // add x5
      set_id(6, 5, 1, 0, 0, 1, 0, 0);                            // reads x5
      @(negedge clk);
      n_run++; if (ctrl !== 4'b1100) begin n_fail++; $display("FAIL b2b_no_stall got=%b exp=1100", ctrl); end
      tick();
      set_id(0, 5, 1, 0, 0, 0, 0, 0);                            // reads x5 one slot later
      @(negedge clk);
      n_run++; if (bus.rs1_forward !== 2'b01) begin n_fail++; $display("FAIL b2b_ex_fwd got=%b exp=01", bus.rs1_forward); end
      tick();
      set_id(0, 0, 0, 0, 0, 1, 0, 0);                            // writes x0
      @(negedge clk);
      n_run++; if (bus.rs1_forward !== 2'b10) begin n_fail++; $display("FAIL b2b_mem_fwd got=%b exp=10", bus.rs1_forward); end
      tick();
      set_id(0, 0, 1, 0, 1, 0, 0, 0);                            // reads x0 twice
      tick();
      set_id(9, 0, 0, 0, 0, 1, 0, 0); tick();                    // two writers of x9
      @(negedge clk);
      n_run++; if ({bus.rs1_forward, bus.rs2_forward} !== 4'b0000)
         begin n_fail++; $display("FAIL b2b_x0_fwd got=%b exp=0000", {bus.rs1_forward, bus.rs2_forward}); end
      set_id(9, 0, 0, 0, 0, 1, 0, 0); tick();
      set_id(0, 0, 0, 9, 1, 0, 0, 0); tick();                    // reads x9
      set_idle();
      @(negedge clk);
      n_run++; if (bus.rs2_forward !== 2'b01) begin n_fail++; $display("FAIL b2b_youngest got=%b exp=01", bus.rs2_forward); end
      tick(); tick();
   endtask

   task automatic test_load_use();
      set_idle(); tick();
      set_id(7, 0, 0, 0, 0, 1, 1, 0); tick();                    // lw x7
      set_id(8, 0, 0, 7, 1, 1, 0, 0);                            // uses x7 as rs2
      @(negedge clk);
      n_run++; if (ctrl !== 4'b0001) begin n_fail++; $display("FAIL lu_stall got=%b exp=0001", ctrl); end
      tick();
      @(negedge clk);
      n_run++; if (ctrl !== 4'b1100) begin n_fail++; $display("FAIL lu_one_cycle got=%b exp=1100", ctrl); end
      n_run++; if (bus.rs2_forward !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_fwd got=%b exp=00", bus.rs2_forward); end
      tick();
      set_idle();
      @(negedge clk);
      n_run++; if (bus.rs2_forward !== 2'b10) begin n_fail++; $display("FAIL lu_mem_fwd got=%b exp=10", bus.rs2_forward); end
      tick(); tick();
   endtask

   task automatic test_branch_load_use();
      set_idle(); tick();
      set_id(7, 0, 0, 0, 0, 1, 1, 0); tick();                    // lw x7
      set_id(8, 7, 1, 7, 1, 1, 0, 0);
      bus.branch_taken = 1'b1;
      @(negedge clk);
      n_run++; if (ctrl !== 4'b1111) begin n_fail++; $display("FAIL br_flush got=%b exp=1111", ctrl); end
      tick();
      set_idle();
      @(negedge clk);
      n_run++; if ({bus.rs1_forward, bus.rs2_forward} !== 4'b0000)
         begin n_fail++; $display("FAIL br_fwd got=%b exp=0000", {bus.rs1_forward, bus.rs2_forward}); end
      n_run++; if (ctrl !== 4'b1100) begin n_fail++; $display("FAIL br_after got=%b exp=1100", ctrl); end
      tick(); tick();
   endtask

   task automatic test_multicycle();
      set_idle(); tick();
      set_id(3, 0, 0, 0, 0, 1, 0, 0); tick();                    // add x3
      set_id(4, 3, 1, 0, 0, 1, 0, 1);                            // div x4, reads x3
      @(negedge clk);
      n_run++; if ({bus.ex_start, ctrl} !== 5'b01100) begin n_fail++; $display("FAIL mc_pre got=%b exp=01100", {bus.ex_start, ctrl}); end
      tick();
      set_id(5, 4, 1, 0, 0, 1, 0, 0);                            // reads x4
      @(negedge clk);
      n_run++; if ({bus.ex_start, ctrl, bus.rs1_forward} !== 7'b1000001)
         begin n_fail++; $display("FAIL mc_start got=%b exp=1000001", {bus.ex_start, ctrl, bus.rs1_forward}); end
      tick();
      for (int i = 1; i <= 5; i++) begin
         bus.ex_done = (i == 5);
         @(negedge clk);
         n_run++; if ({bus.ex_start, ctrl, bus.rs1_forward} !== 7'b0000001)
            begin n_fail++; $display("FAIL mc_frozen i=%0d got=%b exp=0000001", i, {bus.ex_start, ctrl, bus.rs1_forward}); end
         tick();
      end
      bus.ex_done = 1'b0;
      @(negedge clk);
      n_run++; if ({ctrl, bus.rs1_forward} !== 6'b110001) begin n_fail++; $display("FAIL mc_resume got=%b exp=110001", {ctrl, bus.rs1_forward}); end
      tick();
      set_idle();
      @(negedge clk);
      n_run++; if ({bus.ex_start, bus.rs1_forward} !== 3'b001) begin n_fail++; $display("FAIL mc_dep_fwd got=%b exp=001", {bus.ex_start, bus.rs1_forward}); end
      tick();
   endtask

   task automatic test_ext_stall();
      set_idle(); tick(); tick();
      set_id(9, 0, 0, 0, 0, 1, 0, 0); tick();                    // add x9
      set_id(0, 9, 1, 0, 0, 0, 0, 0);                            // reads x9
      bus.ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.branch_taken = (i == 1);
         @(negedge clk);
         n_run++; if ({ctrl, bus.rs1_forward} !== 6'b000000)
            begin n_fail++; $display("FAIL stall_hold i=%0d got=%b exp=000000", i, {ctrl, bus.rs1_forward}); end
         tick();
      end
      bus.ext_stall    = 1'b0;
      bus.branch_taken = 1'b0;
      @(negedge clk);
      n_run++; if (ctrl !== 4'b1100) begin n_fail++; $display("FAIL stall_release got=%b exp=1100", ctrl); end
      tick();
      set_idle();
      @(negedge clk);
      n_run++; if (bus.rs1_forward !== 2'b01) begin n_fail++; $display("FAIL stall_fwd got=%b exp=01", bus.rs1_forward); end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      set_idle(); tick();
      set_id(2, 0, 0, 0, 0, 1, 0, 0); tick();                    // add x2
      set_id(3, 2, 1, 0, 0, 1, 0, 1); tick();                    // div x3, reads x2
      set_idle();
      #2;
      n_run++; if ({bus.ex_start, bus.rs1_forward, ctrl} !== 7'b1010000)
         begin n_fail++; $display("FAIL rstw_pre got=%b exp=1010000", {bus.ex_start, bus.rs1_forward, ctrl}); end
      rst = 1'b1;
      #1;
      n_run++; if ({bus.ex_start, bus.rs1_forward, bus.rs2_forward, ctrl} !== 9'b000001100)
         begin n_fail++; $display("FAIL rstw_async got=%b exp=000001100", {bus.ex_start, bus.rs1_forward, bus.rs2_forward, ctrl}); end
`ifdef HAZARD_PERF_EN
      n_run++; if ({perf_load_use, perf_flush, perf_ex_wait} !== 96'd0)
         begin n_fail++; $display("FAIL rstw_perf got=%0d/%0d/%0d exp=0/0/0", perf_load_use, perf_flush, perf_ex_wait); end
`endif
      @(negedge clk);
      rst = 1'b0;
      tick();
      @(negedge clk);
      n_run++; if ({bus.ex_start, ctrl} !== 5'b01100) begin n_fail++; $display("FAIL rstw_run got=%b exp=01100", {bus.ex_start, ctrl}); end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         bus.id_valid      = ($urandom_range(0, 3) != 0);
         bus.id_rs1        = AW'($urandom_range(0, 3));
         bus.id_rs2        = AW'($urandom_range(0, 3));
         bus.id_rd         = AW'($urandom_range(0, 3));
         bus.id_use_rs1    = 1'($urandom_range(0, 1));
         bus.id_use_rs2    = 1'($urandom_range(0, 1));
         bus.id_reg_write  = ($urandom_range(0, 3) != 0);
         bus.id_mem_read   = ($urandom_range(0, 2) == 0);
         bus.id_multicycle = ($urandom_range(0, 15) == 0);
         bus.ex_done       = ($urandom_range(0, 3) == 0);
         bus.branch_taken  = ($urandom_range(0, 9) == 0);
         bus.ext_stall     = ($urandom_range(0, 9) == 0);
         @(negedge clk);
         n_run++;
         if ({ctrl, bus.ex_start, bus.rs1_forward, bus.rs2_forward} !== {m_ctrl(), m_start, m_f1, m_f2}) begin
            n_fail++;
            $display("FAIL random cyc=%0d ctrl/start/f1/f2 got=%b/%b/%b/%b exp=%b/%b/%b/%b", c,
                     ctrl, bus.ex_start, bus.rs1_forward, bus.rs2_forward, m_ctrl(), m_start, m_f1, m_f2);
         end
`ifdef HAZARD_PERF_EN
         n_run++;
         if ({perf_load_use, perf_flush, perf_ex_wait} !== {m_lu, m_fl, m_ew}) begin
            n_fail++;
            $display("FAIL random_perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c,
                     perf_load_use, perf_flush, perf_ex_wait, m_lu, m_fl, m_ew);
         end
`endif
         tick();
      end
      set_idle();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_load_use();
      test_branch_load_use();
      test_multicycle();
      test_ext_stall();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout after %0d comparisons", n_run);
      $fatal(1);
   end

endmodule
